if_align: RTL

Fetch-alignment buffer between the instruction cache response and decode. It accepts 32-bit fetch words and splits them into 16-bit parcels. It reassembles 32-bit instructions that straddle a word boundary, and presents one instruction per cycle with its PC and a compressed flag. The `d_c_ins` output drives the PC generator's `c_ins` input. `stall_if` is derived from `d_valid`/`d_ready`.

---
 rtl/if_align_if.sv | 28 ++
 rtl/if_align.sv | 117 +++++++++++
 2 files changed

// File: rtl/if_align_if.sv
// Fetch-side and decode-side handshake bundle for the fetch-alignment buffer.
interface if_align_if;
  localparam int unsigned WORD_W = 32;
  localparam int unsigned PC_W   = 64;

  logic              flush;
  logic              f_valid;
  logic [WORD_W-1:0] f_data;
  logic [PC_W-1:0]   f_addr;
  logic              f_ready;
  logic              d_valid;
  logic [WORD_W-1:0] d_ins;
  logic [PC_W-1:0]   d_pc;
  logic              d_c_ins;
  logic              d_ready;

  // Alignment buffer side.
  modport slave (
    input  flush, f_valid, f_data, f_addr, d_ready,
    output f_ready, d_valid, d_ins, d_pc, d_c_ins
  );

  // Fetch/decode environment side.
  modport master (
    output flush, f_valid, f_data, f_addr, d_ready,
    input  f_ready, d_valid, d_ins, d_pc, d_c_ins
  );
endinterface

// File: rtl/if_align.sv
// Fetch-alignment buffer: splits 32-bit fetch words into 16-bit parcels and
// presents one (possibly compressed) instruction per cycle with its PC.
module if_align #(
  parameter int unsigned PARCELS = 4
) (
  input  logic      clk,
  input  logic      rst,
  if_align_if.slave bus
);

  localparam int unsigned PTR_W = (PARCELS > 2) ? $clog2(PARCELS) : 1;
  localparam int unsigned CNT_W = $clog2(PARCELS + 1);

  logic [15:0]      mem [PARCELS];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic [CNT_W-1:0] count;
  logic [63:0]      head_pc;
  logic [63:0]      tail_pc;

  logic [15:0]      head_parcel;
  logic [15:0]      next_parcel;
  logic             head_comp;
  logic             valid_c;
  logic [31:0]      ins_c;
  logic             seq_word;
  logic             non_seq;
  logic             frag;
  logic             drop_frag;
  logic [CNT_W-1:0] space_count;
  logic             ready_c;
  logic             push;
  logic             pop;
  logic [1:0]       push_n;
  logic [1:0]       pop_n;
  logic [CNT_W-1:0] base_count;
  logic [CNT_W-1:0] count_next;
  logic             unused_addr_bit;

  // Pointer advance modulo PARCELS (PARCELS need not be a power of two).
  function automatic logic [PTR_W-1:0] ptr_add(input logic [PTR_W-1:0] p,
                                               input logic [1:0] n);
    logic [PTR_W:0] s;
    s = {1'b0, p} + (PTR_W+1)'(n);
    if (s >= (PTR_W+1)'(PARCELS)) s = s - (PTR_W+1)'(PARCELS);
    return s[PTR_W-1:0];
  endfunction

  // Head decode, fetch acceptance and push/pop sizing.
  always_comb begin
    head_parcel = mem[rd_ptr];
    next_parcel = mem[ptr_add(rd_ptr, 2'd1)];
    head_comp   = head_parcel[1:0] != 2'b11;
    valid_c     = (count != '0) && (head_comp || count >= CNT_W'(2));
    ins_c       = head_comp ? {16'h0, head_parcel} : {next_parcel, head_parcel};
    // A word from a different line than the tail redirects the stream; a lone
    // upper-less 32-bit fragment can never complete, so it is discarded.
    seq_word    = bus.f_addr[63:2] == tail_pc[63:2];
    non_seq     = (count != '0) && !seq_word;
    frag        = (count == CNT_W'(1)) && !head_comp;
    drop_frag   = non_seq && frag;
    space_count = drop_frag ? '0 : count;
    ready_c     = !rst && (!non_seq || drop_frag) &&
                  ((CNT_W'(PARCELS) - space_count) >= CNT_W'(2));
    push        = bus.f_valid && ready_c && !bus.flush;
    pop         = valid_c && bus.d_ready && !bus.flush;
    push_n      = push ? (bus.f_addr[1] ? 2'd1 : 2'd2) : 2'd0;
    pop_n       = pop ? (head_comp ? 2'd1 : 2'd2) : 2'd0;
    base_count  = (push && drop_frag) ? '0 : count;
    count_next  = base_count + CNT_W'(push_n) - CNT_W'(pop_n);
  end

  assign bus.f_ready      = ready_c;
  assign bus.d_valid      = valid_c;
  assign bus.d_ins        = ins_c;
  assign bus.d_pc         = head_pc;
  assign bus.d_c_ins      = (count != '0) && head_comp;
  assign unused_addr_bit  = bus.f_addr[0];

  // Parcel storage, pointers, count and PC tracking.
  always_ff @(posedge clk) begin
    if (rst) begin
      mem     <= '{default: '0};
      rd_ptr  <= '0;
      wr_ptr  <= '0;
      count   <= '0;
      head_pc <= '0;
      tail_pc <= '0;
    end else if (bus.flush) begin
      count  <= '0;
      rd_ptr <= wr_ptr;
    end else begin
      if (push) begin
        if (!bus.f_addr[1]) begin
          mem[wr_ptr]                <= bus.f_data[15:0];
          mem[ptr_add(wr_ptr, 2'd1)] <= bus.f_data[31:16];
        end else begin
          mem[wr_ptr] <= bus.f_data[31:16];
        end
        wr_ptr  <= ptr_add(wr_ptr, push_n);
        tail_pc <= {bus.f_addr[63:2], 2'b00} + 64'd4;
      end
      if (push && drop_frag) begin
        rd_ptr <= wr_ptr;
      end else if (pop) begin
        rd_ptr <= ptr_add(rd_ptr, pop_n);
      end
      if (push && base_count == '0) begin
        head_pc <= {bus.f_addr[63:1], 1'b0};
      end else if (pop) begin
        head_pc <= head_pc + ((pop_n == 2'd2) ? 64'd4 : 64'd2);
      end
      count <= count_next;
    end
  end

endmodule
